// File: rtl/pulpemu_spi_flash_responder.sv
// pulpemu_spi_flash_responder
//   FPGA-side SPI slave (single lane, mode 0) that emulates a boot/data flash.
//   SCK/CSN/MOSI are oversampled in clk_i (clk_i must be >= 8x SCK). Byte-wide
//   reads (0x0B FAST READ) and writes (0x02) are forwarded to an external memory
//   through a req/gnt/rvalid port. Other commands are ignored.
//
//   Optional feature: define PULPEMU_SPIS_READID_EN to answer 0x9F (READ ID)
//   with DEV_ID, repeated MSB first. Without it, 0x9F is ignored like any
//   unknown command.
//
// Ports
//   clk_i, rst_ni        system clock, asynchronous active-low reset
//   spi_sck_i/csn_i/mosi_i  SPI inputs from the master (asynchronous)
//   spi_miso_o, spi_miso_oe_o  slave data out and pad output enable
//   mem_req_o/we_o/addr_o/wdata_o, mem_gnt_i  memory request channel
//   mem_rvalid_i, mem_rdata_i                 memory read-data return
//   busy_o               CSN asserted and a command in progress
//   err_o                sticky underrun/overrun flag, cleared on CSN fall
//   dbg_state_o          current FSM state (encoding of state_e)
//
// Memory handshake: mem_req_o acts as valid and mem_gnt_i as ready; a request
// transfers on a clk_i edge where both are high. While mem_req_o is high and
// mem_gnt_i low, mem_we_o/mem_addr_o/mem_wdata_o hold steady. For a read,
// mem_rvalid_i returns the byte on any cycle after the grant. At most one
// transaction is in flight.

module pulpemu_spi_flash_responder #(
    parameter int unsigned ADDR_W = 24,
    parameter logic [23:0] DEV_ID = 24'hC2_20_18
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              spi_sck_i,
    input  logic              spi_csn_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    output logic              spi_miso_oe_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [7:0]        mem_rdata_i,
    output logic              busy_o,
    output logic              err_o,
    output logic [2:0]        dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_ADDR   = 3'd2,
        S_DUMMY  = 3'd3,
        S_RDATA  = 3'd4,
        S_WDATA  = 3'd5,
        S_ID     = 3'd6,
        S_IGNORE = 3'd7
    } state_e;

    localparam logic [7:0] CMD_FAST_READ = 8'h0B;
    localparam logic [7:0] CMD_WRITE     = 8'h02;
`ifdef PULPEMU_SPIS_READID_EN
    localparam logic [7:0] CMD_READ_ID   = 8'h9F;
`endif

    state_e state;

    // Synchronisers; the third SCK/CSN stage is only for edge detection.
    logic [2:0] sck_sync;
    logic [2:0] csn_sync;
    logic [1:0] mosi_sync;

    logic sck_rise, sck_fall, csn_rise, csn_fall, csn_s, mosi_s;

    assign sck_rise = sck_sync[1] & ~sck_sync[2];
    assign sck_fall = ~sck_sync[1] & sck_sync[2];
    assign csn_rise = csn_sync[1] & ~csn_sync[2];
    assign csn_fall = ~csn_sync[1] & csn_sync[2];
    assign csn_s    = csn_sync[1];
    assign mosi_s   = mosi_sync[1];

    logic [2:0]        bit_cnt;
    logic [4:0]        addr_cnt;
    logic [6:0]        shift_in;
    logic [6:0]        shift_out;
    logic [ADDR_W-1:0] addr_q;     // next address to access
    logic              is_write;
    logic              want_rd;    // a prefetch is owed at addr_q
    logic              rd_wait;    // read granted, waiting for rvalid
    logic              rd_drop;    // discard the next rvalid (aborted read)
    logic [7:0]        pf_data;
    logic              pf_valid;
`ifdef PULPEMU_SPIS_READID_EN
    logic [4:0]        id_idx;
`else
    logic              unused_dev_id;
    assign unused_dev_id = ^DEV_ID;
`endif

    logic [7:0] rx_byte;
    assign rx_byte = {shift_in, mosi_s};

    // Byte available at a read byte boundary: the prefetch buffer, or read
    // data arriving in that very cycle. Otherwise underrun pattern 0xFF.
    logic       rd_avail;
    logic [7:0] rd_byte;
    always_comb begin
        rd_avail = 1'b1;
        rd_byte  = pf_data;
        if (!pf_valid) begin
            if (rd_wait && mem_rvalid_i && !rd_drop) begin
                rd_byte = mem_rdata_i;
            end else begin
                rd_avail = 1'b0;
                rd_byte  = 8'hFF;
            end
        end
    end

    assign busy_o      = ~csn_s & (state != S_IDLE);
    assign dbg_state_o = state;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_sync      <= 3'b000;
            csn_sync      <= 3'b111;
            mosi_sync     <= 2'b00;
            state         <= S_IDLE;
            spi_miso_o    <= 1'b0;
            spi_miso_oe_o <= 1'b0;
            mem_req_o     <= 1'b0;
            mem_we_o      <= 1'b0;
            mem_addr_o    <= '0;
            mem_wdata_o   <= 8'h00;
            err_o         <= 1'b0;
            bit_cnt       <= 3'd0;
            addr_cnt      <= 5'd0;
            shift_in      <= 7'd0;
            shift_out     <= 7'd0;
            addr_q        <= '0;
            is_write      <= 1'b0;
            want_rd       <= 1'b0;
            rd_wait       <= 1'b0;
            rd_drop       <= 1'b0;
            pf_data       <= 8'h00;
            pf_valid      <= 1'b0;
`ifdef PULPEMU_SPIS_READID_EN
            id_idx        <= 5'd23;
`endif
        end else begin
            sck_sync  <= {sck_sync[1:0], spi_sck_i};
            csn_sync  <= {csn_sync[1:0], spi_csn_i};
            mosi_sync <= {mosi_sync[0], spi_mosi_i};

            // Memory side. Later FSM assignments in this block take priority.
            if (mem_req_o && mem_gnt_i) begin
                mem_req_o <= 1'b0;
                if (!mem_we_o) rd_wait <= 1'b1;
            end
            if (rd_wait && mem_rvalid_i) begin
                rd_wait <= 1'b0;
                if (rd_drop) begin
                    rd_drop <= 1'b0;
                end else begin
                    pf_data  <= mem_rdata_i;
                    pf_valid <= 1'b1;
                end
            end
            if (want_rd && !mem_req_o && !rd_wait) begin
                mem_req_o  <= 1'b1;
                mem_we_o   <= 1'b0;
                mem_addr_o <= addr_q;
                addr_q     <= addr_q + ADDR_W'(1);
                want_rd    <= 1'b0;
            end

            if (csn_rise) begin
                state         <= S_IDLE;
                spi_miso_o    <= 1'b0;
                spi_miso_oe_o <= 1'b0;
                mem_req_o     <= 1'b0;
                want_rd       <= 1'b0;
                // A read already granted (or granted right now) still returns
                // data later; that data belongs to nobody.
                if ((rd_wait && !mem_rvalid_i) || (mem_req_o && mem_gnt_i && !mem_we_o))
                    rd_drop <= 1'b1;
            end else if (csn_fall) begin
                state         <= S_CMD;
                bit_cnt       <= 3'd0;
                addr_cnt      <= 5'd0;
                err_o         <= 1'b0;
                pf_valid      <= 1'b0;
                spi_miso_o    <= 1'b0;
                spi_miso_oe_o <= 1'b0;
            end else if (!csn_s) begin
                case (state)
                    S_CMD: begin
                        if (sck_rise) begin
                            shift_in <= rx_byte[6:0];
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                case (rx_byte)
                                    CMD_FAST_READ: begin
                                        state    <= S_ADDR;
                                        is_write <= 1'b0;
                                    end
                                    CMD_WRITE: begin
                                        state    <= S_ADDR;
                                        is_write <= 1'b1;
                                    end
`ifdef PULPEMU_SPIS_READID_EN
                                    CMD_READ_ID: begin
                                        state  <= S_ID;
                                        id_idx <= 5'd23;
                                    end
`endif
                                    default: state <= S_IGNORE;
                                endcase
                            end
                        end
                    end
                    S_ADDR: begin
                        if (sck_rise) begin
                            // Bits beyond ADDR_W fall off the top of the shifter.
                            addr_q   <= {addr_q[ADDR_W-2:0], mosi_s};
                            addr_cnt <= addr_cnt + 5'd1;
                            if (addr_cnt == 5'd23) begin
                                addr_cnt <= 5'd0;
                                if (is_write) begin
                                    state <= S_WDATA;
                                end else begin
                                    state   <= S_DUMMY;
                                    want_rd <= 1'b1;
                                end
                            end
                        end
                    end
                    S_DUMMY: begin
                        if (sck_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) state <= S_RDATA;
                        end
                    end
                    S_RDATA: begin
                        if (sck_fall) begin
                            bit_cnt       <= bit_cnt + 3'd1;
                            spi_miso_oe_o <= 1'b1;
                            if (bit_cnt == 3'd0) begin
                                // Byte boundary: consume prefetch, ask for the next.
                                spi_miso_o <= rd_byte[7];
                                shift_out  <= rd_byte[6:0];
                                pf_valid   <= 1'b0;
                                want_rd    <= 1'b1;
                                if (!rd_avail) err_o <= 1'b1;
                            end else begin
                                spi_miso_o <= shift_out[6];
                                shift_out  <= {shift_out[5:0], 1'b0};
                            end
                        end
                    end
                    S_WDATA: begin
                        if (sck_rise) begin
                            shift_in <= rx_byte[6:0];
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if ((mem_req_o && !mem_gnt_i) || rd_wait) begin
                                    err_o <= 1'b1;
                                end else begin
                                    mem_req_o   <= 1'b1;
                                    mem_we_o    <= 1'b1;
                                    mem_addr_o  <= addr_q;
                                    mem_wdata_o <= rx_byte;
                                    addr_q      <= addr_q + ADDR_W'(1);
                                end
                            end
                        end
                    end
`ifdef PULPEMU_SPIS_READID_EN
                    S_ID: begin
                        if (sck_fall) begin
                            spi_miso_o    <= DEV_ID[id_idx];
                            spi_miso_oe_o <= 1'b1;
                            id_idx        <= (id_idx == 5'd0) ? 5'd23 : id_idx - 5'd1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pulpemu_spi_flash_responder.sv
module tb_pulpemu_spi_flash_responder;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        spi_sck_i, spi_csn_i, spi_mosi_i;
  logic        spi_miso_o, spi_miso_oe_o;
  logic        mem_req_o, mem_we_o;
  logic [23:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [7:0]  mem_rdata_i;
  logic        busy_o, err_o;
  logic [2:0]  dbg_state_o;

  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset
  always #5 clk = ~clk;

  pulpemu_spi_flash_responder dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .spi_sck_i     (spi_sck_i),
    .spi_csn_i     (spi_csn_i),
    .spi_mosi_i    (spi_mosi_i),
    .spi_miso_o    (spi_miso_o),
    .spi_miso_oe_o (spi_miso_oe_o),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .busy_o        (busy_o),
    .err_o         (err_o),
    .dbg_state_o   (dbg_state_o)
  );

  // memory model: grants on the negedge after req is seen, read data 2 clk later
  logic        gnt_stuck = 1'b0;
  logic [23:0] rd_addr_q[$];
  logic [23:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  int          req_cycles = 0;
  int          rv_cnt = 0;
  logic [7:0]  rv_data = 8'h00;

  function automatic logic [7:0] mem_value(input logic [23:0] a);
    case (a)
      24'h000100: return 8'h11;
      24'h000101: return 8'h22;
      24'h000102: return 8'h33;
      24'h000103: return 8'h44;
      default:    return a[7:0] ^ 8'hA5;
    endcase
  endfunction

  always @(negedge clk) begin
    mem_rvalid_i = 1'b0;
    if (rv_cnt > 0) begin
      rv_cnt = rv_cnt - 1;
      if (rv_cnt == 0) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rv_data;
      end
    end
    mem_gnt_i = 1'b0;
    if (mem_req_o === 1'b1) begin
      req_cycles++;
      if (!gnt_stuck) begin
        mem_gnt_i = 1'b1;
        if (mem_we_o) begin
          wr_addr_q.push_back(mem_addr_o);
          wr_data_q.push_back(mem_wdata_o);
        end else begin
          rd_addr_q.push_back(mem_addr_o);
          rv_data = mem_value(mem_addr_o);
          rv_cnt  = 2;
        end
      end
    end
  end

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_begin();
    spi_csn_i = 1'b0;
    wait_clk(6);
  endtask

  task automatic spi_end();
    wait_clk(4);
    spi_csn_i = 1'b1;
    wait_clk(8);
  endtask

  // Sends tx[7] downto tx[8-nbits]; MISO/OE sampled at each rising SCK.
  task automatic spi_bits(input logic [7:0] tx, input int nbits,
                          output logic [7:0] rx, output logic oe_all, output logic oe_any);
    rx = 8'h00; oe_all = 1'b1; oe_any = 1'b0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_mosi_i = tx[i];
      wait_clk(HALF);
      spi_sck_i = 1'b1;
      rx[i]  = spi_miso_o;
      oe_all = oe_all & spi_miso_oe_o;
      oe_any = oe_any | spi_miso_oe_o;
      wait_clk(HALF);
      spi_sck_i = 1'b0;
    end
  endtask

  task automatic clear_log();
    rd_addr_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  // tests
  task automatic test_reset();
    logic [7:0] rx; logic oa, on;
    wait_clk(2);
    n_checks++; if ({spi_miso_o, spi_miso_oe_o, mem_req_o, mem_we_o, busy_o, err_o} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 000000", {spi_miso_o, spi_miso_oe_o, mem_req_o, mem_we_o, busy_o, err_o}); end
    n_checks++; if ({mem_addr_o, mem_wdata_o} !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 00000000", {mem_addr_o, mem_wdata_o}); end
    rst_ni = 1'b1;
    wait_clk(4);
    // write 0x20=0x77, then reset in the middle of the next data byte
    clear_log();
    spi_begin();
    spi_bits(8'h02, 8, rx, oa, on);
    spi_bits(8'h00, 8, rx, oa, on);
    spi_bits(8'h00, 8, rx, oa, on);
    spi_bits(8'h20, 8, rx, oa, on);
    spi_bits(8'h77, 8, rx, oa, on);
    spi_bits(8'hF0, 4, rx, oa, on);
    n_checks++; if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 24'h20 || wr_data_q[0] !== 8'h77) begin
      n_fail++; $display("FAIL pre_reset_write: got %0d writes expected one 0x20=77", wr_addr_q.size()); end
    rst_ni = 1'b0;
    spi_csn_i = 1'b1;
    wait_clk(1);
    n_checks++; if ({mem_we_o, mem_addr_o, mem_wdata_o} !== 33'h0) begin
      n_fail++; $display("FAIL midreset_mem: got we=%b addr=%h wdata=%h expected 0", mem_we_o, mem_addr_o, mem_wdata_o); end
    n_checks++; if ({spi_miso_o, spi_miso_oe_o, mem_req_o, busy_o, err_o, dbg_state_o} !== 8'h0) begin
      n_fail++; $display("FAIL midreset_ctrl: got %b expected 0", {spi_miso_o, spi_miso_oe_o, mem_req_o, busy_o, err_o, dbg_state_o}); end
    wait_clk(2);
    rst_ni = 1'b1;
    wait_clk(4);
    clear_log();
    spi_begin();
    n_checks++; if (dbg_state_o !== 3'd1 || busy_o !== 1'b1) begin
      n_fail++; $display("FAIL after_reset_cmd: got state=%0d busy=%b expected 1 1", dbg_state_o, busy_o); end
    spi_bits(8'h02, 8, rx, oa, on);
    spi_bits(8'h00, 8, rx, oa, on);
    spi_bits(8'h00, 8, rx, oa, on);
    spi_bits(8'h30, 8, rx, oa, on);
    spi_bits(8'h5C, 8, rx, oa, on);
    spi_end();
    n_checks++; if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 24'h30 || wr_data_q[0] !== 8'h5C) begin
      n_fail++; $display("FAIL after_reset_write: got %0d writes expected one 0x30=5C", wr_addr_q.size()); end
  endtask

  task automatic test_fast_read();
    logic [7:0] rx; logic oa, on, hdr_oe;
    logic [7:0] exp_b[4];
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    clear_log();
    spi_begin();
    hdr_oe = 1'b0;
    spi_bits(8'h0B, 8, rx, oa, on); hdr_oe |= on;
    spi_bits(8'h00, 8, rx, oa, on); hdr_oe |= on;
    spi_bits(8'h01, 8, rx, oa, on); hdr_oe |= on;
    spi_bits(8'h00, 8, rx, oa, on); hdr_oe |= on;
    spi_bits(8'h00, 8, rx, oa, on); hdr_oe |= on;
    n_checks++; if (hdr_oe !== 1'b0) begin
      n_fail++; $display("FAIL read_hdr_oe: got %b expected 0", hdr_oe); end
    for (int b = 0; b < 4; b++) begin
      spi_bits(8'h00, 8, rx, oa, on);
      n_checks++; if (rx !== exp_b[b] || oa !== 1'b1) begin
        n_fail++; $display("FAIL read_byte%0d: got %h oe=%b expected %h oe=1", b, rx, oa, exp_b[b]); end
    end
    n_checks++; if (err_o !== 1'b0) begin
      n_fail++; $display("FAIL read_err: got %b expected 0", err_o); end
    spi_end();
    n_checks++; if (spi_miso_oe_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL read_end: got oe=%b busy=%b expected 0 0", spi_miso_oe_o, busy_o); end
    n_checks++; if (rd_addr_q.size() < 5) begin
      n_fail++; $display("FAIL read_addr_count: got %0d expected >=5", rd_addr_q.size()); end
    else begin
      for (int k = 0; k < 5; k++) begin
        n_checks++; if (rd_addr_q[k] !== 24'h100 + 24'(k)) begin
          n_fail++; $display("FAIL read_addr%0d: got %h expected %h", k, rd_addr_q[k], 24'h100 + 24'(k)); end
      end
    end
  endtask

  task automatic test_write_wrap();
    logic [7:0] rx; logic oa, on;
    clear_log();
    spi_begin();
    spi_bits(8'h02, 8, rx, oa, on);
    spi_bits(8'hFF, 8, rx, oa, on);
    spi_bits(8'hFF, 8, rx, oa, on);
    spi_bits(8'hFF, 8, rx, oa, on);
    spi_bits(8'hAA, 8, rx, oa, on);
    spi_bits(8'hBB, 8, rx, oa, on);
    spi_bits(8'hC3, 3, rx, oa, on);
    spi_end();
    wait_clk(4);
    n_checks++; if (wr_addr_q.size() != 2) begin
      n_fail++; $display("FAIL wrap_count: got %0d expected 2", wr_addr_q.size()); end
    else begin
      n_checks++; if (wr_addr_q[0] !== 24'hFFFFFF || wr_data_q[0] !== 8'hAA) begin
        n_fail++; $display("FAIL wrap_w0: got %h=%h expected FFFFFF=AA", wr_addr_q[0], wr_data_q[0]); end
      n_checks++; if (wr_addr_q[1] !== 24'h000000 || wr_data_q[1] !== 8'hBB) begin
        n_fail++; $display("FAIL wrap_w1: got %h=%h expected 000000=BB", wr_addr_q[1], wr_data_q[1]); end
    end
    n_checks++; if (err_o !== 1'b0) begin
      n_fail++; $display("FAIL wrap_err: got %b expected 0", err_o); end
  endtask

  task automatic test_underrun();
    logic [7:0] rx; logic oa, on;
    clear_log();
    gnt_stuck = 1'b1;
    spi_begin();
    spi_bits(8'h0B, 8, rx, oa, on);
    spi_bits(8'h00, 8, rx, oa, on);
    spi_bits(8'h03, 8, rx, oa, on);
    spi_bits(8'h00, 8, rx, oa, on);
    spi_bits(8'h00, 8, rx, oa, on);
    spi_bits(8'h00, 8, rx, oa, on);
    n_checks++; if (rx !== 8'hFF || err_o !== 1'b1) begin
      n_fail++; $display("FAIL underrun_byte: got %h err=%b expected FF err=1", rx, err_o); end
    n_checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 24'h300 || mem_we_o !== 1'b0) begin
      n_fail++; $display("FAIL underrun_req_hold: got req=%b addr=%h we=%b expected 1 300 0", mem_req_o, mem_addr_o, mem_we_o); end
    spi_end();
    n_checks++; if (mem_req_o !== 1'b0 || err_o !== 1'b1) begin
      n_fail++; $display("FAIL underrun_abort: got req=%b err=%b expected 0 1", mem_req_o, err_o); end
    gnt_stuck = 1'b0;
    spi_begin();
    n_checks++; if (err_o !== 1'b0) begin
      n_fail++; $display("FAIL underrun_clear: got %b expected 0", err_o); end
    spi_end();
    n_checks++; if (rd_addr_q.size() != 0) begin
      n_fail++; $display("FAIL underrun_no_read: got %0d reads expected 0", rd_addr_q.size()); end
  endtask

  task automatic test_write_overrun();
    logic [7:0] rx; logic oa, on;
    clear_log();
    gnt_stuck = 1'b1;
    spi_begin();
    spi_bits(8'h02, 8, rx, oa, on);
    spi_bits(8'h00, 8, rx, oa, on);
    spi_bits(8'h00, 8, rx, oa, on);
    spi_bits(8'h10, 8, rx, oa, on);
    spi_bits(8'h5A, 8, rx, oa, on);
    spi_bits(8'h6B, 8, rx, oa, on);
    n_checks++; if (err_o !== 1'b1 || mem_wdata_o !== 8'h5A) begin
      n_fail++; $display("FAIL overrun_flag: got err=%b wdata=%h expected 1 5A", err_o, mem_wdata_o); end
    gnt_stuck = 1'b0;
    wait_clk(4);
    spi_end();
    n_checks++; if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 24'h10 || wr_data_q[0] !== 8'h5A) begin
      n_fail++; $display("FAIL overrun_writes: got %0d writes expected one 0x10=5A", wr_addr_q.size()); end
  endtask

  task automatic test_read_id();
    logic [7:0] rx; logic oa, on;
    logic [7:0] exp_b[4];
    int req0;
`ifdef PULPEMU_SPIS_READID_EN
    exp_b = '{8'hC2, 8'h20, 8'h18, 8'hC2};
`else
    exp_b = '{8'h00, 8'h00, 8'h00, 8'h00};
`endif
    req0 = req_cycles;
    spi_begin();
    spi_bits(8'h9F, 8, rx, oa, on);
    for (int b = 0; b < 4; b++) begin
      spi_bits(8'h00, 8, rx, oa, on);
      n_checks++; if (rx !== exp_b[b]) begin
        n_fail++; $display("FAIL id_byte%0d: got %h expected %h", b, rx, exp_b[b]); end
`ifdef PULPEMU_SPIS_READID_EN
      n_checks++; if (oa !== 1'b1) begin
        n_fail++; $display("FAIL id_oe%0d: got %b expected 1", b, oa); end
`else
      n_checks++; if (on !== 1'b0) begin
        n_fail++; $display("FAIL id_oe%0d: got %b expected 0", b, on); end
`endif
    end
    spi_end();
    n_checks++; if (req_cycles != req0) begin
      n_fail++; $display("FAIL id_no_mem: got %0d req cycles expected 0", req_cycles - req0); end
  endtask

  task automatic test_unknown_then_read();
    logic [7:0] rx; logic oa, on;
    int req0;
    clear_log();
    req0 = req_cycles;
    spi_begin();
    spi_bits(8'h55, 8, rx, oa, on);
    spi_bits(8'h00, 8, rx, oa, on);
    n_checks++; if (rx !== 8'h00 || on !== 1'b0) begin
      n_fail++; $display("FAIL unknown_b0: got %h oe=%b expected 00 0", rx, on); end
    spi_bits(8'hFF, 8, rx, oa, on);
    n_checks++; if (rx !== 8'h00 || on !== 1'b0) begin
      n_fail++; $display("FAIL unknown_b1: got %h oe=%b expected 00 0", rx, on); end
    spi_end();
    n_checks++; if (req_cycles != req0) begin
      n_fail++; $display("FAIL unknown_no_mem: got %0d req cycles expected 0", req_cycles - req0); end
    spi_begin();
    spi_bits(8'h0B, 8, rx, oa, on);
    spi_bits(8'h00, 8, rx, oa, on);
    spi_bits(8'h02, 8, rx, oa, on);
    spi_bits(8'h00, 8, rx, oa, on);
    spi_bits(8'h00, 8, rx, oa, on);
    spi_bits(8'h00, 8, rx, oa, on);
    n_checks++; if (rx !== 8'hA5 || oa !== 1'b1) begin
      n_fail++; $display("FAIL after_unknown_b0: got %h oe=%b expected A5 1", rx, oa); end
    spi_bits(8'h00, 8, rx, oa, on);
    n_checks++; if (rx !== 8'hA4) begin
      n_fail++; $display("FAIL after_unknown_b1: got %h expected A4", rx); end
    n_checks++; if (err_o !== 1'b0) begin
      n_fail++; $display("FAIL after_unknown_err: got %b expected 0", err_o); end
    spi_end();
    n_checks++; if (rd_addr_q.size() < 1 || rd_addr_q[0] !== 24'h200) begin
      n_fail++; $display("FAIL after_unknown_addr: got %0d reads expected first at 000200", rd_addr_q.size()); end
  endtask

  // watchdog
  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst_ni       = 1'b0;
    spi_sck_i    = 1'b0;
    spi_csn_i    = 1'b1;
    spi_mosi_i   = 1'b0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 8'h00;
    test_reset();
    test_fast_read();
    test_write_wrap();
    test_underrun();
    test_write_overrun();
    test_read_id();
    test_unknown_then_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
